// File: rtl/lock_timer_pkg.sv
// lock_timer_pkg: shared state encoding and sizing helpers for the lock timer
package lock_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int div_of(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    function automatic int pre_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: free-running divide-by-DIV counter emitting a one-cycle tick
module tick_prescaler
    import lock_timer_pkg::*;
#(
    parameter int DIV = 100
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int PW = pre_width(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] r_cnt;

    // counts 0..DIV-1 and wraps; only reset ever clears it
    always_ff @(posedge clk) begin
        if (!rst_n) r_cnt <= '0;
        else r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + PW'(1);
    end

    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/lock_timer_ctrl.sv
// lock_timer_ctrl: scan tick, one-second tick and loadable seconds countdown.
// Optional macro LOCK_TIMER_PAUSE_EN adds a pause input that freezes the countdown.
module lock_timer_ctrl
    import lock_timer_pkg::*;
#(
    parameter int CLK_HZ  = 100000000,
    parameter int TICK_HZ = 100,
    parameter int SEC_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cancel,
`ifdef LOCK_TIMER_PAUSE_EN
    input  logic             pause,
`endif
    input  logic [SEC_W-1:0] load_sec,
    output logic             tick_100hz,
    output logic             sec_pulse,
    output logic             busy,
    output logic [SEC_W-1:0] remain_sec,
    output logic             expire
);

    localparam int DIV = div_of(CLK_HZ, TICK_HZ);
    localparam int SW  = pre_width(TICK_HZ);
    localparam logic [SW-1:0] SUB_LAST = SW'(TICK_HZ - 1);

    generate
        if ((CLK_HZ % TICK_HZ) != 0 || DIV < 2) begin : g_bad_div
            $error("lock_timer_ctrl: CLK_HZ must be an exact multiple (>=2x) of TICK_HZ");
        end
    endgenerate

    state_t           r_state;
    logic [SW-1:0]    r_sub;
    logic [SEC_W-1:0] r_remain;
    logic             r_busy;
    logic             r_expire;
    logic             r_sec_pulse;
    logic             w_tick;
    logic             w_pause;
    logic             w_start;
    logic             w_load_zero;
    logic             w_count;

    tick_prescaler #(.DIV(DIV)) u_pre (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

`ifdef LOCK_TIMER_PAUSE_EN
    assign w_pause = pause;
`else
    assign w_pause = 1'b0;
`endif

    // cancel always beats a simultaneous start
    assign w_start     = start & ~cancel;
    assign w_load_zero = (load_sec == '0);
    assign w_count     = w_tick & ~w_pause;

    // countdown FSM; outputs are registered so expire/sec_pulse land one cycle after their cause
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_sub       <= '0;
            r_remain    <= '0;
            r_busy      <= 1'b0;
            r_expire    <= 1'b0;
            r_sec_pulse <= 1'b0;
        end else begin
            r_expire    <= 1'b0;
            r_sec_pulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_sub <= '0;
                    if (w_start && w_load_zero) begin
                        r_expire <= 1'b1;
                    end else if (w_start) begin
                        r_state  <= RUN;
                        r_busy   <= 1'b1;
                        r_remain <= load_sec;
                    end
                end
                RUN: begin
                    if (cancel) begin
                        r_state  <= IDLE;
                        r_busy   <= 1'b0;
                        r_remain <= '0;
                        r_sub    <= '0;
                    end else if (w_start && w_load_zero) begin
                        r_state  <= IDLE;
                        r_busy   <= 1'b0;
                        r_remain <= '0;
                        r_sub    <= '0;
                        r_expire <= 1'b1;
                    end else if (w_start) begin
                        r_remain <= load_sec;
                        r_sub    <= '0;
                    end else if (w_count && r_sub == SUB_LAST) begin
                        r_sub       <= '0;
                        r_sec_pulse <= 1'b1;
                        r_remain    <= r_remain - SEC_W'(1);
                        if (r_remain == SEC_W'(1)) begin
                            r_state  <= DONE;
                            r_busy   <= 1'b0;
                            r_expire <= 1'b1;
                        end
                    end else if (w_count) begin
                        r_sub <= r_sub + SW'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_sub   <= '0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign tick_100hz = w_tick;
    assign sec_pulse  = r_sec_pulse;
    assign busy       = r_busy;
    assign remain_sec = r_remain;
    assign expire     = r_expire;

endmodule

// File: tb/tb_lock_timer_ctrl.sv
// tb_lock_timer_ctrl: scoreboard bench for lock_timer_ctrl (pause test under LOCK_TIMER_PAUSE_EN)
module tb_lock_timer_ctrl;

    localparam int CLK_HZ  = 1000;
    localparam int TICK_HZ = 10;
    localparam int SEC_W   = 8;
    localparam int DIV     = CLK_HZ / TICK_HZ;

    typedef struct {
        int cyc;
        bit sp;
        bit ex;
        int rem;
    } ev_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             cancel = 1'b0;
    logic             pause = 1'b0;
    logic [SEC_W-1:0] load_sec = '0;
    logic             tick_100hz;
    logic             sec_pulse;
    logic             busy;
    logic [SEC_W-1:0] remain_sec;
    logic             expire;

    int  cyc = 0;
    int  n_cmp = 0;
    int  n_bad = 0;
    ev_t q[$];
    int  m_bs = 0, m_be = 0, m_done = -1, m_lc = -1, m_L = 0;
    int  ps = 0, pe = 0;

    lock_timer_ctrl #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .SEC_W(SEC_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cancel     (cancel),
`ifdef LOCK_TIMER_PAUSE_EN
        .pause      (pause),
`endif
        .load_sec   (load_sec),
        .tick_100hz (tick_100hz),
        .sec_pulse  (sec_pulse),
        .busy       (busy),
        .remain_sec (remain_sec),
        .expire     (expire)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, want %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // drop expected events that a command at cycle ts pre-empts
    function automatic void trim(input int ts);
        while (q.size() != 0 && q[$].cyc > ts) void'(q.pop_back());
    endfunction

    // enumerate scan ticks after ts, skipping paused cycles; every TICK_HZ-th is a second
    function automatic int gen(input int ts, input int L);
        int c = ts + 1 + (DIV - 1 - ((ts + 1) % DIV));
        int cnt = 0;
        int k = 0;
        int last = c;
        while (k < L) begin
            if (!(c >= ps && c < pe)) begin
                cnt++;
                if (cnt % TICK_HZ == 0) begin
                    k++;
                    q.push_back('{c + 1, 1'b1, k == L, L - k});
                    last = c;
                end
            end
            c += DIV;
        end
        return last;
    endfunction

    function automatic void model_cmd(input int ts, input bit s, input bit cn, input int L);
        bit run = (ts >= m_bs && ts < m_be);
        bit done = (ts == m_done);
        int bl;
        if (cn) begin
            if (run) begin
                trim(ts);
                m_be = ts + 1;
                m_done = -1;
            end
        end else if (s && !done) begin
            trim(ts);
            if (L == 0) begin
                q.push_back('{ts + 1, 1'b0, 1'b1, 0});
                if (run) begin
                    m_be = ts + 1;
                    m_done = -1;
                end
            end else begin
                if (!run) m_bs = ts + 1;
                m_L = L;
                m_lc = ts + 1;
                bl = gen(ts, L);
                m_be = bl + 1;
                m_done = bl + 1;
            end
        end
    endfunction

    task automatic issue(input bit s, input bit cn, input int L);
        start = s;
        cancel = cn;
        load_sec = SEC_W'(L);
        model_cmd(cyc, s, cn, L);
        step(1);
        start = 1'b0;
        cancel = 1'b0;
    endtask

    // monitor: per-cycle tick/busy/remain checks and scoreboard pops on output pulses
    always @(negedge clk) begin
        bit  eb;
        ev_t ev;
        if (rst_n) begin
            eb = (cyc >= m_bs && cyc < m_be);
            check("tick_100hz", int'(tick_100hz), int'((cyc % DIV) == DIV - 1));
            check("busy", int'(busy), int'(eb));
            if (!eb) check("remain_idle", int'(remain_sec), 0);
            else if (cyc == m_lc) check("remain_load", int'(remain_sec), m_L);
            while (q.size() != 0 && q[0].cyc < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL missed_event at cycle %0d: got none, want event at %0d", cyc, q[0].cyc);
                void'(q.pop_front());
            end
            if (q.size() != 0 && q[0].cyc == cyc) begin
                ev = q.pop_front();
                check("sec_pulse", int'(sec_pulse), int'(ev.sp));
                check("expire", int'(expire), int'(ev.ex));
                check("remain_evt", int'(remain_sec), ev.rem);
            end else if (sec_pulse || expire) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_event at cycle %0d: got sp=%0d ex=%0d, want none",
                         cyc, sec_pulse, expire);
            end
        end
    end

    initial begin
        step(5);
        rst_n = 1'b1;
        step(1000);
        issue(1, 0, 3);
        step(3200);
        issue(1, 0, 5);
        step(1500);
        issue(0, 1, 0);
        step(6000);
        issue(1, 0, 0);
        step(10);
        issue(1, 0, 4);
        step(1199);
        issue(1, 0, 2);
        step(2300);
        issue(1, 0, 3);
        step(500);
        issue(1, 1, 2);
        step(1500);
        issue(1, 0, 1);
        step(m_done - cyc);
        issue(1, 1, 3);
        step(200);
        issue(0, 1, 0);
        issue(1, 0, 2);
        step(700);
        issue(1, 0, 0);
        step(20);
        for (int i = 0; i < 12; i++) begin
            int r, L;
            step($urandom_range(1, 2500));
            r = $urandom_range(0, 9);
            L = $urandom_range(0, 3);
            if (r < 5) issue(1, 0, L);
            else if (r < 8) issue(0, 1, 0);
            else issue(1, 1, L);
        end
        step(4000);
`ifdef LOCK_TIMER_PAUSE_EN
        ps = cyc + 500;
        pe = ps + 3000;
        issue(1, 0, 2);
        step(ps - cyc);
        pause = 1'b1;
        step(3000);
        pause = 1'b0;
        step(3000);
`endif
        step(50);
        check("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lock_timer_ctrl.md
Name: lock_timer_ctrl

Overview:
Timebase and timeout controller for the password-lock design. It replaces free-running derived clocks with single-cycle clock-enable ticks: a free-running 100 Hz scan tick, plus a one-second tick. It also runs a loadable seconds countdown that the lock FSM uses for entry timeout and wrong-code lockout. All logic is on one clock domain; it produces no divided clocks.

Parameters:
CLK_HZ, 100000000, input clock frequency in Hz
TICK_HZ, 100, scan tick rate; DIV = CLK_HZ/TICK_HZ; CLK_HZ must be an exact multiple of TICK_HZ (elaboration-time check)
SEC_W, 8, width of seconds countdown (max 255 s)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
start  in  1  single-cycle request: load load_sec and begin countdown
cancel  in  1  single-cycle request: abort countdown, no expire
load_sec  in  SEC_W  countdown length in seconds, sampled when start is accepted
tick_100hz  out  1  one-cycle pulse every DIV clocks, free-running
sec_pulse  out  1  one-cycle pulse on each countdown second boundary (RUN only)
busy  out  1  high while state is RUN
remain_sec  out  SEC_W  seconds remaining
expire  out  1  one-cycle pulse when countdown reaches 0

Behaviour:
- Clock is clk; reset is synchronous, active-low (rst_n). Reset is sampled on the clk edge only.
- Reset values: prescaler=0, sub_cnt=0, state=IDLE, remain_sec=0, busy=0, expire=0, sec_pulse=0, tick_100hz=0.
- Prescaler: counts 0..DIV-1 and wraps. It runs in every state and is never cleared by start or cancel.
- tick_100hz is high exactly in the cycle where prescaler==DIV-1. Period is DIV cycles.
- sub_cnt: counts ticks 0..TICK_HZ-1, in RUN only. It is cleared to 0 on accepted start, on cancel, and in IDLE.
- A second boundary occurs in the cycle where tick_100hz=1 and sub_cnt==TICK_HZ-1.
- State IDLE:
  - start=1 and load_sec!=0: go to RUN next edge, remain_sec<=load_sec, sub_cnt<=0.
  - start=1 and load_sec==0: stay IDLE; expire=1 in the next cycle.
- State RUN:
  - At a second boundary: remain_sec<=remain_sec-1 and sec_pulse=1 in the following cycle.
  - If remain_sec==1 at the boundary: remain_sec<=0, go to DONE.
- State DONE: lasts one cycle with expire=1 and busy=0, then goes to IDLE unconditionally. start is ignored in DONE.
- start while in RUN: restart with the new load_sec (load_sec==0 is treated as cancel plus expire). sub_cnt is reset, so the first second after a restart is between DIV*(TICK_HZ-1)+1 and DIV*TICK_HZ cycles long.
- cancel in RUN: go to IDLE, remain_sec<=0, no expire. cancel in IDLE or DONE has no effect.
- start and cancel in the same cycle: cancel wins and start is dropped.
- Boundary and start in the same cycle in RUN: start wins (reload); no decrement and no sec_pulse.
- expire and sec_pulse are registered and last exactly one cycle. They are never asserted together except on the final second, where both are high in the DONE cycle.
- busy is registered and equals (state==RUN).
- remain_sec never wraps below 0.

Optional Feature:
LOCK_TIMER_PAUSE_EN:
- Defined: adds input port pause (1 bit). While pause=1 in RUN, sub_cnt, remain_sec and sec_pulse are frozen and busy stays 1. The prescaler and tick_100hz keep running. cancel and start are still honoured during pause.
- Undefined: the pause port does not exist and behaviour is exactly as above.

Decomposition:
- Package lock_timer_pkg holds:
  - the state enum (IDLE, RUN, DONE)
  - a constant function computing DIV and the prescaler width via $clog2(DIV)
- Sub-module tick_prescaler (parameter DIV; ports clk, rst_n, tick) implements the free-running prescaler. It is reused by the keypad scanner.

Test Plan (sim params CLK_HZ=1000, TICK_HZ=10: DIV=100, one second = 1000 cycles):
- Reset release, idle for 1000 cycles -> tick_100hz pulses at cycles 99, 199, ... (10 pulses); busy=0, remain_sec=0, expire never high.
- start with load_sec=3 -> busy=1 next cycle, remain_sec=3; sec_pulse 3 times at 1000-cycle spacing; remain_sec goes 2,1,0; one expire pulse with final sec_pulse; busy=0 after.
- start with load_sec=5, cancel after 1500 cycles -> remain_sec=0, busy=0 next cycle; no expire for 6000 further cycles.
- start with load_sec=0 in IDLE -> expire=1 exactly one cycle later; busy never asserts.
- start with load_sec=4, restart with load_sec=2 at cycle 1200 -> remain_sec=2; expire about 2000 cycles after the restart; start and cancel in the same cycle -> cancel wins.
- LOCK_TIMER_PAUSE_EN: start with load_sec=2, pause high for 3000 cycles mid-count -> remain_sec is held; expire is delayed by 3000 cycles; tick_100hz continues throughout.
